// File: rtl/tree_root_driver.sv
// tree_root_driver: launches the root node of an evaluation tree through the
// ST/RD start-ready handshake and returns its result. A per-request watchdog
// abandons nodes that never acknowledge or never finish.
module tree_root_driver #(
  parameter int W       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REQ,
  input  logic [W-1:0] ARG0,
  input  logic [W-1:0] ARG1,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR,
  output logic [W-1:0] RESULT,
  output logic         ST,
  output logic [W-1:0] IN0,
  output logic [W-1:0] IN1,
  input  logic         RD,
  input  logic [W-1:0] RES
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    LAUNCH = 2'd2,
    WAIT   = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_t         state_q, state_d;
  logic           st_q, st_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [W-1:0]   in0_q, in0_d;
  logic [W-1:0]   in1_q, in1_d;
  logic [W-1:0]   result_q, result_d;
  logic [15:0]    wd_q, wd_d;
  logic [15:0]    wd_inc;
  logic           expired;
  logic           complete;

  // State and output registers; RST returns everything to the idle values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      st_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      in0_q    <= '0;
      in1_q    <= '0;
      result_q <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      st_q     <= st_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
      result_q <= result_d;
      wd_q     <= wd_d;
    end
  end

  // Next-state logic; the watchdog counts the current cycle, so expiry lands
  // exactly TIMEOUT cycles after acceptance, and a completion in that same
  // cycle takes priority over the timeout.
  always_comb begin
    state_d  = state_q;
    st_d     = st_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    in0_d    = in0_q;
    in1_d    = in1_q;
    result_d = result_q;
    wd_d     = wd_q;
    wd_inc   = wd_q + 16'd1;
    expired  = (wd_inc == TIMEOUT_C);
    complete = (state_q == WAIT) && RD;

    case (state_q)
      IDLE: begin
        st_d = 1'b0;
        if (REQ) begin
          in0_d   = ARG0;
          in1_d   = ARG1;
          err_d   = 1'b0;
          wd_d    = '0;
          busy_d  = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        wd_d = wd_inc;
        if (RD) begin
          st_d    = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        wd_d = wd_inc;
        if (!RD) begin
          st_d    = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        wd_d = wd_inc;
        if (RD) begin
          result_d = RES;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && !complete && expired) begin
      err_d   = 1'b1;
      done_d  = 1'b1;
      st_d    = 1'b0;
      busy_d  = 1'b0;
      state_d = IDLE;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign ERR    = err_q;
  assign RESULT = result_q;
  assign ST     = st_q;
  assign IN0    = in0_q;
  assign IN1    = in1_q;

endmodule

// File: doc/tree_root_driver.md
# tree_root_driver

Initiator for the node start/ready protocol: takes a request with two operands, launches the root node of an evaluation tree, waits for its completion and returns the node's result. It sits between the host-side request logic and the top node, driving the node's ST/IN0/IN1 and observing its RD/RES. A per-request watchdog reports nodes that never acknowledge or never finish.

## Interface
- W, 16, data width of operands and result
- TIMEOUT, 255, maximum cycles from leaving IDLE to completion (1..65535)

- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- REQ  in  1  request; sampled only in IDLE
- ARG0  in  W  operand 0, captured with accepted REQ
- ARG1  in  W  operand 1, captured with accepted REQ
- BUSY  out  1  high from acceptance until return to IDLE
- DONE  out  1  one-cycle completion pulse (success or timeout)
- ERR  out  1  timeout flag for the last request, held until next acceptance
- RESULT  out  W  captured node result, held until next success
- ST  out  1  node start, registered
- IN0  out  W  node operand 0, registered, stable for whole request
- IN1  out  W  node operand 1, registered, stable for whole request
- RD  in  1  node ready (1 = idle/result valid, 0 = working)
- RES  in  W  node result, valid when RD=1 after acknowledge

## Operation
- Node contract: node starts on a rising edge of ST (sampled low then high), drops RD the cycle it samples that edge, raises RD when RES is valid.
- States: IDLE, ARM, LAUNCH, WAIT.
- IDLE: ST=0, BUSY=0. REQ=1 -> IN0<=ARG0, IN1<=ARG1, ERR<=0, watchdog<=0, BUSY<=1, go ARM.
- ARM: ST=0 (guarantees a low sample before the edge). RD=1 -> ST<=1, go LAUNCH; RD=0 -> stay (node still busy).
- LAUNCH: ST held 1. RD=0 sampled (acknowledge) -> ST<=0, go WAIT.
- WAIT: ST=0. RD=1 -> RESULT<=RES, DONE<=1, BUSY<=0, go IDLE.
- Watchdog: increments every cycle in ARM/LAUNCH/WAIT; when it equals TIMEOUT and no completion that cycle -> ERR<=1, DONE<=1, ST<=0, BUSY<=0, RESULT unchanged, go IDLE.
- Completion and timeout in the same cycle: completion wins, ERR stays 0.
- REQ outside IDLE ignored; no queuing.
- REQ in the IDLE cycle where DONE is high is accepted normally.
- Reset (any state, including mid-request): state IDLE, ST=0, IN0=0, IN1=0, BUSY=0, DONE=0, ERR=0, RESULT=0, watchdog=0.

## Timing
- All outputs registered; no combinational paths from inputs to outputs.
- REQ sampled at edge e -> ARM from e; ST=1 from edge e+1 (when RD=1).
- Single-cycle node (acknowledge one edge after ST, RD high two edges later): RD=0 sampled e+3, RD=1 sampled e+5 -> DONE and valid RESULT from edge e+5; REQ-to-DONE latency 5 cycles.
- ST high for exactly 2 cycles with such a node; low for at least 1 cycle between requests.
- Back-to-back: next REQ accepted in the DONE cycle; next ST rise no earlier than 2 cycles after previous ST fall.
- Timeout: DONE/ERR asserted from edge e+TIMEOUT at latest.

## Test plan
- Reset, then IN0=0x1234/IN1=0x5678 REQ with projection node (RES=IN0) -> ST high 2 cycles, DONE 5 cycles after REQ, RESULT=0x1234, ERR=0.
- Two back-to-back requests (0x0001, 0xBEEF) with REQ held high -> two DONE pulses, RESULT 0x0001 then 0xBEEF, ST low between launches.
- Node model holding RD=0 forever, TIMEOUT=10 -> DONE and ERR=1 at 10 cycles after acceptance, RESULT keeps previous value, ST=0; next good request clears ERR.
- Node model acknowledging but raising RD exactly on watchdog expiry -> success, ERR=0, RESULT captured.
- RST asserted in WAIT -> next cycle all outputs at reset values, no DONE; fresh request then completes normally.
- REQ toggled while BUSY with different ARG values -> ignored, IN0/IN1 unchanged, single DONE.
